// File: rtl/mips_int_ctrl.sv
// -----------------------------------------------------------------------------
// mips_int_ctrl
//
// Interrupt controller driving the single INT request line of the pipelined
// MIPS core. Each peripheral line is edge detected and latched into a pending
// bit. A software mask gates the pending bits, and the lowest-index unmasked
// source is presented to the core. A three-state handshake follows:
// request, then acknowledge on handler entry, then end-of-interrupt on eret.
//
// Optional feature macro: MIPS_INT_CTRL_SYNC_EN
//   defined   - each irq_in bit passes through a 2-flop synchronizer before
//               edge detect; asynchronous sources are allowed and the
//               edge-to-INT latency grows by two cycles.
//   undefined - irq_in feeds edge detect directly; sources must already be
//               synchronous to clk.
//
// Parameters:
//   N_SRC       number of interrupt source lines (2..32)
//   ID_W        source id width, 2**ID_W >= N_SRC
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   irq_in      peripheral request lines, rising edge requests
//   mask_we     mask register write strobe
//   mask_wdata  new mask value, 1 = source enabled
//   int_ack     core has redirected to the handler (one-cycle pulse)
//   eoi         core executed eret (one-cycle pulse)
//   INT         interrupt request to the core
//   int_id      id of the requested / in-service source
//   in_service  a handler is active
//   pending     raw pending bits, not masked
// -----------------------------------------------------------------------------

// Per-source slice: optional synchronizer, rising-edge detect and pending bit.
module mips_int_line (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pend
);
    logic irq_s;
    logic prev;
    logic rise;

`ifdef MIPS_INT_CTRL_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], irq};
    end

    assign irq_s = sync[1];
`else
    assign irq_s = irq;
`endif

    // prev resets low, so a line already high at reset release produces
    // exactly one request.
    assign rise = irq_s & ~prev;

    // A new edge in the same cycle as the ack of this source wins: the
    // fresh request must not be lost behind the one being serviced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= irq_s;
            pend <= (pend & ~clr) | rise;
        end
    end
endmodule

module mips_int_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             INT,
    output logic [ID_W-1:0]  int_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [N_SRC-1:0]  mask;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  clr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   id_nxt;
    logic              int_nxt;
    logic              ins_nxt;
    logic              ack_take;

    // Source slices.
    for (genvar i = 0; i < N_SRC; i++) begin : g_line
        mips_int_line u_line (
            .clk  (clk),
            .rst  (rst),
            .irq  (irq_in[i]),
            .clr  (clr[i]),
            .pend (pending[i])
        );
    end

    // Mask register; masking only gates arbitration, pending bits survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          mask <= '1;
        else if (mask_we) mask <= mask_wdata;
    end

    assign req = pending & mask;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) winner = ID_W'(i);
        end
    end

    // Ack clears only the latched source, never the current winner.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = ack_take && (int_id == ID_W'(i));
        end
    end

    // Next-state and next-output logic. Outputs are computed here and
    // registered alongside the state so the core sees clean flop outputs.
    always_comb begin
        state_nxt = state;
        id_nxt    = int_id;
        int_nxt   = INT;
        ins_nxt   = in_service;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = REQ;
                    id_nxt    = winner;
                    int_nxt   = 1'b1;
                end
            end
            // int_id is frozen here: later arrivals or mask writes do not
            // retract or retarget a request the core may already be taking.
            REQ: begin
                if (int_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = SERVICE;
                    int_nxt   = 1'b0;
                    ins_nxt   = 1'b1;
                end
            end
            // int_ack is ignored here even when paired with eoi. Returning
            // to IDLE guarantees INT is low for at least one cycle.
            SERVICE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                    ins_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                int_nxt   = 1'b0;
                ins_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            int_id     <= '0;
            INT        <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            int_id     <= id_nxt;
            INT        <= int_nxt;
            in_service <= ins_nxt;
        end
    end
endmodule

// File: tb/tb_mips_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_int_ctrl: directed, self-checking bench for mips_int_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled at that point too,
// so every value seen reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_mips_int_ctrl;
    localparam int N_SRC = 8;
    localparam int ID_W  = 3;
`ifdef MIPS_INT_CTRL_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] irq_in;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;
    logic             int_ack;
    logic             eoi;
    logic             INT;
    logic [ID_W-1:0]  int_id;
    logic             in_service;
    logic [N_SRC-1:0] pending;

    int checks = 0;
    int errors = 0;

    mips_int_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .INT        (INT),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse an edge on the given lines; pending is set after the first tick.
    task automatic pulse_irq(input logic [N_SRC-1:0] v);
        irq_in = v;
        tick(1 + EXTRA);
        irq_in = '0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = 8'h01; mask_we = 1'b0; mask_wdata = '0;
        int_ack = 1'b0; eoi = 1'b0;
        tick(2);
        checks++;
        if (INT !== 1'b0 || int_id !== 3'd0 || in_service !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals INT=%b id=%0d ins=%b pend=%h want 0 0 0 00", INT, int_id, in_service, pending);
        end
        rst = 1'b0;
        tick(1 + EXTRA);
        checks++;
        if (pending !== 8'h01 || INT !== 1'b0) begin
            errors++;
            $display("FAIL held_line_pend pend=%h INT=%b want 01 0", pending, INT);
        end
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd0) begin
            errors++;
            $display("FAIL held_line_req INT=%b id=%0d want 1 0", INT, int_id);
        end
        do_ack();
        checks++;
        if (INT !== 1'b0 || in_service !== 1'b1 || pending !== 8'h00) begin
            errors++;
            $display("FAIL held_line_ack INT=%b ins=%b pend=%h want 0 1 00", INT, in_service, pending);
        end
        do_eoi();
        checks++;
        if (in_service !== 1'b0 || INT !== 1'b0) begin
            errors++;
            $display("FAIL held_line_eoi ins=%b INT=%b want 0 0", in_service, INT);
        end
        tick(4);
        checks++;
        if (INT !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL held_line_once INT=%b pend=%h want 0 00", INT, pending);
        end
        irq_in = '0;
        tick(1 + EXTRA);
    endtask

    task automatic test_priority();
        pulse_irq(8'h24);
        checks++;
        if (pending !== 8'h24) begin
            errors++;
            $display("FAIL prio_pend pend=%h want 24", pending);
        end
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd2) begin
            errors++;
            $display("FAIL prio_first INT=%b id=%0d want 1 2", INT, int_id);
        end
        do_ack();
        checks++;
        if (pending !== 8'h20 || in_service !== 1'b1) begin
            errors++;
            $display("FAIL prio_ack pend=%h ins=%b want 20 1", pending, in_service);
        end
        do_eoi();
        checks++;
        if (INT !== 1'b0 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL prio_gap INT=%b ins=%b want 0 0", INT, in_service);
        end
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd5) begin
            errors++;
            $display("FAIL prio_second INT=%b id=%0d want 1 5", INT, int_id);
        end
        do_ack();
        do_eoi();
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_wdata = 8'hFB;
        tick();
        mask_we = 1'b0;
        pulse_irq(8'h04);
        tick(2);
        checks++;
        if (pending !== 8'h04 || INT !== 1'b0) begin
            errors++;
            $display("FAIL mask_block pend=%h INT=%b want 04 0", pending, INT);
        end
        mask_we = 1'b1; mask_wdata = 8'hFF;
        tick();
        mask_we = 1'b0;
        checks++;
        if (INT !== 1'b0) begin
            errors++;
            $display("FAIL mask_lat INT=%b want 0", INT);
        end
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd2) begin
            errors++;
            $display("FAIL mask_open INT=%b id=%0d want 1 2", INT, int_id);
        end
        do_ack();
        do_eoi();
    endtask

    task automatic test_frozen();
        pulse_irq(8'h10);
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd4) begin
            errors++;
            $display("FAIL frozen_req INT=%b id=%0d want 1 4", INT, int_id);
        end
        pulse_irq(8'h02);
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd4 || pending !== 8'h12) begin
            errors++;
            $display("FAIL frozen_hold INT=%b id=%0d pend=%h want 1 4 12", INT, int_id, pending);
        end
        do_ack();
        checks++;
        if (in_service !== 1'b1 || int_id !== 3'd4 || pending !== 8'h02) begin
            errors++;
            $display("FAIL frozen_ack ins=%b id=%0d pend=%h want 1 4 02", in_service, int_id, pending);
        end
        do_eoi();
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd1) begin
            errors++;
            $display("FAIL frozen_next INT=%b id=%0d want 1 1", INT, int_id);
        end
        do_ack();
        do_eoi();
    endtask

    task automatic test_ack_collision();
        pulse_irq(8'h08);
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd3) begin
            errors++;
            $display("FAIL coll_req INT=%b id=%0d want 1 3", INT, int_id);
        end
        // Time the new edge so it reaches edge detect on the ack edge.
        irq_in = 8'h08;
        if (EXTRA > 0) tick(EXTRA);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0; irq_in = '0;
        checks++;
        if (pending !== 8'h08 || in_service !== 1'b1) begin
            errors++;
            $display("FAIL coll_setwins pend=%h ins=%b want 08 1", pending, in_service);
        end
        tick(2);
        do_eoi();
        checks++;
        if (INT !== 1'b0) begin
            errors++;
            $display("FAIL coll_gap INT=%b want 0", INT);
        end
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd3) begin
            errors++;
            $display("FAIL coll_rereq INT=%b id=%0d want 1 3", INT, int_id);
        end
        // eoi in REQ must be ignored; ack+eoi in SERVICE acts as eoi only.
        do_eoi();
        checks++;
        if (INT !== 1'b1 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL eoi_in_req INT=%b ins=%b want 1 0", INT, in_service);
        end
        do_ack();
        int_ack = 1'b1; eoi = 1'b1;
        tick();
        int_ack = 1'b0; eoi = 1'b0;
        checks++;
        if (INT !== 1'b0 || in_service !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL ack_eoi_svc INT=%b ins=%b pend=%h want 0 0 00", INT, in_service, pending);
        end
        tick(2);
    endtask

    task automatic test_reset_mid();
        mask_we = 1'b1; mask_wdata = 8'h40;
        tick();
        mask_we = 1'b0;
        pulse_irq(8'h40);
        tick();
        do_ack();
        pulse_irq(8'h01);
        checks++;
        if (in_service !== 1'b1 || pending !== 8'h01) begin
            errors++;
            $display("FAIL mid_setup ins=%b pend=%h want 1 01", in_service, pending);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (INT !== 1'b0 || int_id !== 3'd0 || in_service !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL mid_async INT=%b id=%0d ins=%b pend=%h want 0 0 0 00", INT, int_id, in_service, pending);
        end
        #1 rst = 1'b0;
        eoi = 1'b1; int_ack = 1'b1;
        tick();
        eoi = 1'b0; int_ack = 1'b0;
        tick();
        checks++;
        if (INT !== 1'b0 || in_service !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL mid_stray INT=%b ins=%b pend=%h want 0 0 00", INT, in_service, pending);
        end
        // Mask came back as all ones, so bit 0 is served again.
        pulse_irq(8'h01);
        tick();
        checks++;
        if (INT !== 1'b1 || int_id !== 3'd0) begin
            errors++;
            $display("FAIL mid_maskrst INT=%b id=%0d want 1 0", INT, int_id);
        end
        do_ack();
        do_eoi();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mask();
        test_frozen();
        test_ack_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
